// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single pmem port between IFU and LSU.
// One outstanding transaction, round-robin grant, response timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          RESET_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    input  logic [1:0]  lsu_size,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic [1:0]  mem_size,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] LP_TLAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_owner;
    logic        r_err;
    logic [15:0] r_cnt;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_wen;
    logic [7:0]  r_mem_wmask;
    logic [1:0]  r_mem_size;
    logic [31:0] r_ifu_rdata;
    logic [31:0] r_lsu_rdata;

    logic w_gnt_ifu;
    logic w_gnt_lsu;
    logic w_busy;
    logic w_done;
    logic w_abort;

    // r_last / r_owner: 1 = LSU, 0 = IFU
    assign w_gnt_ifu = ifu_req_valid && (!lsu_req_valid || r_last);
    assign w_gnt_lsu = lsu_req_valid && (!ifu_req_valid || !r_last);
    assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_done    = (r_state == S_WAIT) && mem_resp_valid;
    assign w_abort   = w_busy && !w_done && (r_cnt == LP_TLAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_ifu || w_gnt_lsu) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_abort) begin
                    w_next = S_RESP;
                end else if (mem_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_done || w_abort) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        resp_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ifu_req_ready = w_gnt_ifu;
                lsu_req_ready = w_gnt_lsu;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
            end
            S_RESP: begin
                ifu_resp_valid = !r_owner;
                lsu_resp_valid = r_owner;
                resp_err       = r_err;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last      <= RESET_LAST;
            r_owner     <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 16'd0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wen   <= 1'b0;
            r_mem_wmask <= 8'h0;
            r_mem_size  <= 2'd0;
            r_ifu_rdata <= 32'h0;
            r_lsu_rdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_ifu) begin
                        r_mem_addr  <= ifu_addr;
                        r_mem_wdata <= 32'h0;
                        r_mem_wen   <= 1'b0;
                        r_mem_wmask <= 8'h0;
                        r_mem_size  <= 2'd2;
                        r_owner     <= 1'b0;
                        r_last      <= 1'b0;
                        r_cnt       <= 16'd0;
                        r_err       <= 1'b0;
                    end else if (w_gnt_lsu) begin
                        r_mem_addr  <= lsu_addr;
                        r_mem_wdata <= lsu_wdata;
                        r_mem_wen   <= lsu_wen;
                        r_mem_wmask <= lsu_wmask;
                        r_mem_size  <= lsu_size;
                        r_owner     <= 1'b1;
                        r_last      <= 1'b1;
                        r_cnt       <= 16'd0;
                        r_err       <= 1'b0;
                    end
                end
                S_REQ, S_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_done) begin
                        if (r_owner) begin
                            r_lsu_rdata <= r_mem_wen ? 32'h0 : mem_rdata;
                        end else begin
                            r_ifu_rdata <= mem_rdata;
                        end
                    end else if (w_abort) begin
                        r_err <= 1'b1;
                        if (r_owner) begin
                            r_lsu_rdata <= 32'h0;
                        end else begin
                            r_ifu_rdata <= 32'h0;
                        end
                    end
                end
                S_RESP: begin
                    r_err <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wen   = r_mem_wen;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
    assign mem_size  = r_mem_size;
    assign ifu_rdata = r_ifu_rdata;
    assign lsu_rdata = r_lsu_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a small
// behavioural memory that can stall, stay silent or be hand-driven.
module tb_mem_arbiter;

    typedef struct packed {
        logic        lsu;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic [1:0]  lsu_size;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [1:0]  mem_size;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    bit          manual    = 1'b0;
    bit          mute      = 1'b0;
    int          ready_lat = 0;
    bit          pending   = 1'b0;
    int          wcnt      = 0;
    logic [31:0] pend_data = 32'h0;

    mem_arbiter #(
        .TIMEOUT    (8),
        .RESET_LAST (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_size       (lsu_size),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_size       (mem_size),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) begin
            return 32'h0010_0073;
        end
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: ready after ready_lat stalled cycles, data one cycle later
    initial begin
        forever begin
            @(negedge clk);
            if (!manual) begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                if (pending) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = pend_data;
                    pending        = 1'b0;
                end else if (mem_req_valid) begin
                    if (wcnt >= ready_lat) begin
                        mem_req_ready = 1'b1;
                        wcnt          = 0;
                        if (!mute) begin
                            pending   = 1'b1;
                            pend_data = mem_word(mem_addr);
                        end
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        pending       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic issue_ifu(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = a;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (ifu_req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic issue_lsu(
        input  logic [31:0] a,
        input  logic        wen,
        input  logic [31:0] wd,
        input  logic [7:0]  wm,
        input  logic [1:0]  sz,
        output bit          ok
    );
        ok = 1'b0;
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = a;
        lsu_wen       = wen;
        lsu_wdata     = wd;
        lsu_wmask     = wm;
        lsu_size      = sz;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (lsu_req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        #1;
        lsu_req_valid = 1'b0;
    endtask

    // Waits (bounded) for a response pulse; lat counts negedges
    task automatic wait_resp(
        output bit          got,
        output bit          is_lsu,
        output bit          err,
        output logic [31:0] rd,
        output int          lat,
        output bit          both
    );
        got    = 1'b0;
        is_lsu = 1'b0;
        err    = 1'b0;
        rd     = 32'h0;
        lat    = 0;
        both   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid) begin
                got    = 1'b1;
                lat    = i;
                is_lsu = lsu_resp_valid;
                both   = ifu_resp_valid && lsu_resp_valid;
                err    = resp_err;
                rd     = lsu_resp_valid ? lsu_rdata : ifu_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({mem_req_valid, ifu_req_ready, lsu_req_ready,
             ifu_resp_valid, lsu_resp_valid, resp_err,
             mem_wen} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {mem_req_valid, ifu_req_ready, lsu_req_ready,
                      ifu_resp_valid, lsu_resp_valid, resp_err,
                      mem_wen});
        end
        n_vec++;
        if ({mem_addr, mem_wdata, mem_wmask, mem_size,
             ifu_rdata, lsu_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h wd=%h wm=%h sz=%0d",
                     mem_addr, mem_wdata, mem_wmask, mem_size);
        end
    endtask

    task automatic test_arbitration();
        exp_t        e;
        bit          got, isl, er, both;
        logic [31:0] rd;
        int          lat;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ifu_req_valid = 1'b1;
            ifu_addr      = 32'h8000_0000 + 32'(k * 4);
            lsu_req_valid = 1'b1;
            lsu_addr      = 32'h8000_1000 + 32'(k * 4);
            lsu_wen       = 1'b0;
            lsu_wdata     = 32'h0;
            lsu_wmask     = 8'h0;
            lsu_size      = 2'd0;
            #1;
            n_vec++;
            if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
                n_err++;
                $display("FAIL arb_tie_ifu[%0d]: got %b want 10", k,
                         {ifu_req_ready, lsu_req_ready});
            end
            @(posedge clk);
            e.lsu   = 1'b0;
            e.err   = 1'b0;
            e.rdata = mem_word(ifu_addr);
            sb.push_back(e);
            #1;
            ifu_req_valid = 1'b0;
            n_vec++;
            if (lsu_req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL arb_busy_ready[%0d]: got %b want 0",
                         k, lsu_req_ready);
            end
            wait_resp(got, isl, er, rd, lat, both);
            e = sb.pop_front();
            n_vec++;
            if (!got || both || {isl, er, rd} !== {e.lsu, e.err, e.rdata})
            begin
                n_err++;
                $display("FAIL arb_ifu_resp[%0d]: got %0b/%0b/%0b/%h want %0b/0/%0b/%h",
                         k, got, both, isl, rd, e.lsu, e.err, e.rdata);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL arb_lsu_next[%0d]: got %b want 01", k,
                         {ifu_req_ready, lsu_req_ready});
            end
            @(posedge clk);
            e.lsu   = 1'b1;
            e.err   = 1'b0;
            e.rdata = mem_word(lsu_addr);
            sb.push_back(e);
            #1;
            lsu_req_valid = 1'b0;
            n_vec++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_size} !==
                {1'b1, 32'h8000_1000 + 32'(k * 4), 1'b0, 2'd0}) begin
                n_err++;
                $display("FAIL arb_lsu_req[%0d]: got v=%b a=%h w=%b s=%0d",
                         k, mem_req_valid, mem_addr, mem_wen, mem_size);
            end
            wait_resp(got, isl, er, rd, lat, both);
            e = sb.pop_front();
            n_vec++;
            if (!got || both || {isl, er, rd} !== {e.lsu, e.err, e.rdata})
            begin
                n_err++;
                $display("FAIL arb_lsu_resp[%0d]: got %0b/%0b/%0b/%h want 1/0/%h",
                         k, got, both, isl, rd, e.rdata);
            end
        end
    endtask

    task automatic test_ifu_fetch();
        exp_t        e;
        bit          ok, got, isl, er, both;
        logic [31:0] rd;
        int          lat;
        issue_ifu(32'h8000_0000, ok);
        e.lsu   = 1'b0;
        e.err   = 1'b0;
        e.rdata = 32'h0010_0073;
        sb.push_back(e);
        n_vec++;
        if (!ok || {mem_req_valid, mem_addr, mem_wen, mem_wmask,
                    mem_size} !== {1'b1, 32'h8000_0000, 1'b0, 8'h0,
                                   2'd2}) begin
            n_err++;
            $display("FAIL ifu_req: ok=%0b v=%b a=%h w=%b m=%h s=%0d",
                     ok, mem_req_valid, mem_addr, mem_wen, mem_wmask,
                     mem_size);
        end
        wait_resp(got, isl, er, rd, lat, both);
        e = sb.pop_front();
        n_vec++;
        if (!got || both || lat != 3 ||
            {isl, er, rd} !== {e.lsu, e.err, e.rdata}) begin
            n_err++;
            $display("FAIL ifu_fetch: got %0b lsu=%0b err=%0b rd=%h lat=%0d want lsu=0 err=0 rd=%h lat=3",
                     got, isl, er, rd, lat, e.rdata);
        end
        @(negedge clk);
        n_vec++;
        if ({ifu_resp_valid, ifu_rdata} !== {1'b0, 32'h0010_0073}) begin
            n_err++;
            $display("FAIL ifu_hold: got v=%b rd=%h want v=0 rd=00100073",
                     ifu_resp_valid, ifu_rdata);
        end
    endtask

    task automatic test_store();
        exp_t        e;
        bit          ok, got, isl, er, both;
        logic [31:0] rd;
        int          lat;
        ready_lat = 5;
        issue_lsu(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0F, 2'd2, ok);
        e.lsu   = 1'b1;
        e.err   = 1'b0;
        e.rdata = 32'h0;
        sb.push_back(e);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL store_grant: got ok=0 want 1");
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wdata,
                 mem_wmask} !== {1'b1, 32'h8000_0010, 1'b1,
                                 32'hDEAD_BEEF, 8'h0F}) begin
                n_err++;
                $display("FAIL store_hold[%0d]: got v=%b a=%h w=%b d=%h m=%h",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wdata,
                         mem_wmask);
            end
        end
        wait_resp(got, isl, er, rd, lat, both);
        e = sb.pop_front();
        n_vec++;
        if (!got || both || lat != 2 ||
            {isl, er, rd} !== {e.lsu, e.err, e.rdata}) begin
            n_err++;
            $display("FAIL store_resp: got %0b lsu=%0b err=%0b rd=%h lat=%0d want lsu=1 err=0 rd=0 lat=2",
                     got, isl, er, rd, lat);
        end
        ready_lat = 0;
    endtask

    task automatic test_timeout();
        exp_t        e;
        bit          ok, got, isl, er, both;
        logic [31:0] rd;
        int          lat;
        mute = 1'b1;
        issue_ifu(32'h8000_0040, ok);
        e.lsu   = 1'b0;
        e.err   = 1'b1;
        e.rdata = 32'h0;
        sb.push_back(e);
        wait_resp(got, isl, er, rd, lat, both);
        e = sb.pop_front();
        n_vec++;
        if (!ok || !got || lat != 9 || mem_req_valid !== 1'b0 ||
            {isl, er, rd} !== {e.lsu, e.err, e.rdata}) begin
            n_err++;
            $display("FAIL timeout_wait: got %0b lsu=%0b err=%0b rd=%h lat=%0d want lsu=0 err=1 rd=0 lat=9",
                     got, isl, er, rd, lat);
        end
        mute      = 1'b0;
        ready_lat = 100;
        issue_lsu(32'h8000_0044, 1'b0, 32'h0, 8'h0, 2'd2, ok);
        e.lsu   = 1'b1;
        e.err   = 1'b1;
        e.rdata = 32'h0;
        sb.push_back(e);
        wait_resp(got, isl, er, rd, lat, both);
        e = sb.pop_front();
        n_vec++;
        if (!ok || !got || lat != 9 || mem_req_valid !== 1'b0 ||
            {isl, er, rd} !== {e.lsu, e.err, e.rdata}) begin
            n_err++;
            $display("FAIL timeout_req: got %0b lsu=%0b err=%0b rd=%h lat=%0d want lsu=1 err=1 rd=0 lat=9",
                     got, isl, er, rd, lat);
        end
        ready_lat = 0;
        issue_ifu(32'h8000_0000, ok);
        e.lsu   = 1'b0;
        e.err   = 1'b0;
        e.rdata = 32'h0010_0073;
        sb.push_back(e);
        wait_resp(got, isl, er, rd, lat, both);
        e = sb.pop_front();
        n_vec++;
        if (!ok || !got || lat != 3 ||
            {isl, er, rd} !== {e.lsu, e.err, e.rdata}) begin
            n_err++;
            $display("FAIL timeout_recover: got %0b lsu=%0b err=%0b rd=%h lat=%0d want lsu=0 err=0 rd=%h lat=3",
                     got, isl, er, rd, lat, e.rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        manual         = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        issue_lsu(32'h8000_1234, 1'b0, 32'h0, 8'h0, 2'd1, ok);
        @(negedge clk);
        n_vec++;
        if (!ok || mem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait_req: got ok=%0b v=%b want 1/1",
                     ok, mem_req_valid);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        n_vec++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, resp_err,
             mem_addr} !== '0) begin
            n_err++;
            $display("FAIL rst_wait_abort: got v=%b ir=%b lr=%b e=%b a=%h",
                     mem_req_valid, ifu_resp_valid, lsu_resp_valid,
                     resp_err, mem_addr);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid,
                 lsu_rdata} !== '0) begin
                n_err++;
                $display("FAIL rst_wait_late[%0d]: got v=%b ir=%b lr=%b rd=%h",
                         i, mem_req_valid, ifu_resp_valid, lsu_resp_valid,
                         lsu_rdata);
            end
        end
    endtask

    task automatic test_spurious_resp();
        exp_t        e;
        bit          ok, got, isl, er, both;
        logic [31:0] rd;
        int          lat;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, resp_err,
                 ifu_rdata, lsu_rdata} !== '0) begin
                n_err++;
                $display("FAIL spurious[%0d]: got v=%b ir=%b lr=%b e=%b ird=%h lrd=%h",
                         i, mem_req_valid, ifu_resp_valid, lsu_resp_valid,
                         resp_err, ifu_rdata, lsu_rdata);
            end
        end
        manual = 1'b0;
        issue_ifu(32'h8000_0000, ok);
        e.lsu   = 1'b0;
        e.err   = 1'b0;
        e.rdata = 32'h0010_0073;
        sb.push_back(e);
        wait_resp(got, isl, er, rd, lat, both);
        e = sb.pop_front();
        n_vec++;
        if (!ok || !got || lat != 3 ||
            {isl, er, rd} !== {e.lsu, e.err, e.rdata}) begin
            n_err++;
            $display("FAIL spurious_after: got %0b lsu=%0b err=%0b rd=%h lat=%0d want lsu=0 err=0 rd=%h lat=3",
                     got, isl, er, rd, lat, e.rdata);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_addr       = 32'h0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = 32'h0;
        lsu_wen        = 1'b0;
        lsu_wdata      = 32'h0;
        lsu_wmask      = 8'h0;
        lsu_size       = 2'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        test_reset();
        test_arbitration();
        test_ifu_fetch();
        test_store();
        test_timeout();
        test_reset_in_wait();
        test_spurious_resp();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port (DPI pmem bridge) between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Needed once the core moves from combinational same-cycle pmem access to multi-cycle fetch/execute.
- Holds one outstanding transaction at a time, arbitrates round-robin, routes the response back to the winning requester, and enforces a response timeout.

Parameters:
- TIMEOUT, 255, cycles allowed in REQ+WAIT before the transaction is aborted with an error (1..65535).
- RESET_LAST, 1, initial value of last_grant (1 = LSU), so IFU wins the first tie after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ifu_req_valid  in  1  IFU request valid
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  IFU fetch address (always a 4-byte read)
- ifu_resp_valid  out  1  one-cycle pulse; ifu_rdata valid
- ifu_rdata  out  32  fetched word
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  32  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  32  store data
- lsu_wmask  in  8  store byte mask
- lsu_size  in  2  0=1B, 1=2B, 2=4B read length
- lsu_resp_valid  out  1  one-cycle pulse; load data or store ack
- lsu_rdata  out  32  load data (0 for stores)
- resp_err  out  1  qualifies the current ifu/lsu_resp_valid pulse as a timeout
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr  out  32
- mem_wen  out  1
- mem_wdata  out  32
- mem_wmask  out  8
- mem_size  out  2
- mem_resp_valid  in  1  memory response valid
- mem_rdata  in  32

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=RESET_LAST.
  - All *_resp_valid, resp_err, mem_req_valid, mem_wen = 0.
  - mem_addr, mem_wdata, mem_wmask, mem_size, ifu_rdata, lsu_rdata, timeout counter = 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Grant is combinational. If only one valid, that requester wins. If both valid, the requester opposite last_grant wins.
  - The winner's req_ready = 1; the loser's = 0. Both readies are 0 outside IDLE.
  - On valid&ready: latch addr/wen/wdata/wmask/size into the mem_* registers. IFU latches wen=0, wmask=0, size=2.
  - Record the owner, set last_grant, clear the counter, go to REQ.
- REQ:
  - mem_req_valid=1; mem_* held stable until mem_req_ready.
  - On mem_req_ready: mem_req_valid drops next cycle; go to WAIT.
- WAIT:
  - On mem_resp_valid: capture mem_rdata into the owner's rdata (store → 0); go to RESP.
  - mem_resp_valid in the same cycle as mem_req_ready (while in REQ) is not accepted. Memory must respond in a later cycle.
- RESP:
  - Owner's resp_valid=1 for exactly one cycle; the non-owner's resp_valid stays 0.
  - Then IDLE. A new grant is possible on the following cycle.
- Minimum latency: request handshake at cycle N, mem_req_valid at N+1, resp_valid at N+3 (ready at N+1, response at N+2).
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without completion: drop mem_req_valid and go to RESP with resp_err=1, owner rdata=32'h0.
- Stray mem_resp_valid in IDLE, REQ or RESP is ignored.
- Reset mid-transaction aborts immediately: no resp pulse, state returns to IDLE.
- rdata outputs hold their last value between pulses.
- Requesters must hold valid and payload stable until ready. The arbiter never grants both requesters in the same cycle.

Test Plan:
- IFU alone, ifu_addr=0x80000000, memory ready immediately and responds next cycle with 0x00100073 -> ifu_resp_valid at cycle N+3 with ifu_rdata=0x00100073, lsu_resp_valid stays 0.
- IFU and LSU both valid from reset with RESET_LAST=1 -> IFU granted first; LSU load (addr 0x80001000, size 0) granted next; a second simultaneous pair is granted IFU again (alternation verified over 4 grants).
- LSU store, addr 0x80000010, wdata 0xDEADBEEF, wmask 0x0F -> mem_* carry those values with mem_wen=1 and stay stable while mem_req_ready is held low 5 cycles; lsu_resp_valid pulse with lsu_rdata=0.
- TIMEOUT=8, memory never responds -> resp_valid pulse to the owner with resp_err=1 and rdata 0; arbiter accepts a new request afterwards.
- Reset asserted in WAIT, then a late mem_resp_valid -> no resp pulse, state IDLE, mem_req_valid=0.
- Spurious mem_resp_valid in IDLE -> no outputs change.
